// File: rtl/output_pkg.sv
// Shared types and constants for the indicator write sequencer.
// Requester ids double as arbiter grant values.
package output_pkg;

  localparam int unsigned PORTS     = 4;
  localparam int unsigned NIB_W     = 4;
  localparam int unsigned PORT_ID_W = 2;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the requester that did not win last time is chosen.
// Purely combinational; ready is one-hot and only asserted while enabled.
module rr_arbiter2
  import output_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] ready,
  output logic       grant
);

  always_comb begin
    ready = 2'b00;
    grant = REQ_A;
    case (valid)
      2'b01:   grant = REQ_A;
      2'b10:   grant = REQ_B;
      2'b11:   grant = ~last_grant;
      default: grant = REQ_A;
    endcase
    if (enable && (valid != 2'b00)) begin
      ready[grant] = 1'b1;
    end
  end

endmodule

// File: rtl/output_write_sequencer.sv
// Arbitrates two requesters onto the indicator write bus and serialises each accepted word
// into one registered nibble write per selected port, lowest port first.
module output_write_sequencer #(
  parameter int unsigned PORTS = output_pkg::PORTS,
  parameter int unsigned NIB_W = output_pkg::NIB_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       a_valid,
  input  logic [PORTS*NIB_W-1:0]     a_word,
  input  logic [PORTS-1:0]           a_mask,
  output logic                       a_ready,
  input  logic                       b_valid,
  input  logic [PORTS*NIB_W-1:0]     b_word,
  input  logic [PORTS-1:0]           b_mask,
  output logic                       b_ready,
  output logic                       rw,
  output logic [NIB_W-1:0]           data,
  output logic [$clog2(PORTS)-1:0]   port_id,
  output logic                       busy,
  output logic                       done,
  output logic                       done_id
);

  import output_pkg::*;

  localparam int unsigned WORD_W = PORTS * NIB_W;
  localparam int unsigned PID_W  = $clog2(PORTS);

  state_e             state_q, state_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic [PORTS-1:0]   mask_q, mask_d;
  logic               id_q, id_d;
  logic               last_q, last_d;
  logic               rw_q, rw_d;
  logic [NIB_W-1:0]   data_q, data_d;
  logic [PID_W-1:0]   pid_q, pid_d;
  logic               done_q, done_d;
  logic               done_id_q, done_id_d;

  logic [1:0]         arb_ready;
  logic               arb_grant;
  logic               handshake;

  logic [WORD_W-1:0]  sel_word;
  logic [PORTS-1:0]   sel_mask;
  logic [PID_W-1:0]   low_pid;
  logic [NIB_W-1:0]   low_nib;
  logic [PORTS-1:0]   low_rest;

  rr_arbiter2 u_arb (
    .valid      ({b_valid, a_valid}),
    .last_grant (last_q),
    .enable     (state_q == ST_IDLE),
    .ready      (arb_ready),
    .grant      (arb_grant)
  );

  assign a_ready   = arb_ready[0];
  assign b_ready   = arb_ready[1];
  assign handshake = |arb_ready;

  // In IDLE the first write is issued straight from the granted request so it lands
  // on the cycle right after the handshake.
  always_comb begin
    if (state_q == ST_IDLE) begin
      sel_word = (arb_grant == REQ_B) ? b_word : a_word;
      sel_mask = (arb_grant == REQ_B) ? b_mask : a_mask;
    end else begin
      sel_word = word_q;
      sel_mask = mask_q;
    end
  end

  // Descending scan so the lowest set bit is the last one to win.
  always_comb begin
    low_pid  = '0;
    low_nib  = '0;
    low_rest = sel_mask & (sel_mask - PORTS'(1));
    for (int i = PORTS - 1; i >= 0; i--) begin
      if (sel_mask[i]) begin
        low_pid = PID_W'(i);
        low_nib = sel_word[i*NIB_W +: NIB_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    mask_d    = mask_q;
    id_d      = id_q;
    last_d    = last_q;
    rw_d      = 1'b0;
    data_d    = '0;
    pid_d     = '0;
    done_d    = 1'b0;
    done_id_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          id_d   = arb_grant;
          last_d = arb_grant;
          word_d = sel_word;
          if (sel_mask == '0) begin
            mask_d    = '0;
            state_d   = ST_DONE;
            done_d    = 1'b1;
            done_id_d = arb_grant;
          end else begin
            state_d = ST_WRITE;
            rw_d    = 1'b1;
            pid_d   = low_pid;
            data_d  = low_nib;
            mask_d  = low_rest;
          end
        end
      end

      ST_WRITE: begin
        if (mask_q == '0) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          done_id_d = id_q;
        end else begin
          rw_d   = 1'b1;
          pid_d  = low_pid;
          data_d = low_nib;
          mask_d = low_rest;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      word_q    <= '0;
      mask_q    <= '0;
      id_q      <= REQ_A;
      last_q    <= REQ_B;
      rw_q      <= 1'b0;
      data_q    <= '0;
      pid_q     <= '0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      mask_q    <= mask_d;
      id_q      <= id_d;
      last_q    <= last_d;
      rw_q      <= rw_d;
      data_q    <= data_d;
      pid_q     <= pid_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
    end
  end

  assign rw      = rw_q;
  assign data    = data_q;
  assign port_id = pid_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_output_write_sequencer.sv
// Directed scenario bench for output_write_sequencer; a negedge monitor logs writes,
// completions and handshakes with cycle stamps for each scenario to check.
module tb_output_write_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [15:0] a_word = '0, b_word = '0;
  logic [3:0]  a_mask = '0, b_mask = '0;
  logic        a_ready, b_ready;
  logic        rw;
  logic [3:0]  data;
  logic [1:0]  port_id;
  logic        busy, done, done_id;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {int c; logic [1:0] p; logic [3:0] d;} wr_t;
  typedef struct {int c; logic id;} ev_t;
  wr_t wq[$];
  ev_t dq[$];
  ev_t hq[$];

  output_write_sequencer dut (
    .clock   (clock),
    .reset   (reset),
    .a_valid (a_valid),
    .a_word  (a_word),
    .a_mask  (a_mask),
    .a_ready (a_ready),
    .b_valid (b_valid),
    .b_word  (b_word),
    .b_mask  (b_mask),
    .b_ready (b_ready),
    .rw      (rw),
    .data    (data),
    .port_id (port_id),
    .busy    (busy),
    .done    (done),
    .done_id (done_id)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (rw === 1'b1) wq.push_back('{c: cyc, p: port_id, d: data});
    if (done === 1'b1) dq.push_back('{c: cyc, id: done_id});
    if (a_valid && a_ready === 1'b1) hq.push_back('{c: cyc, id: 1'b0});
    if (b_valid && b_ready === 1'b1) hq.push_back('{c: cyc, id: 1'b1});
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_logs();
    wq.delete();
    dq.delete();
    hq.delete();
  endtask

  task automatic do_reset();
    a_valid = 1'b0;
    b_valid = 1'b0;
    reset   = 1'b0;
    ticks(2);
    reset = 1'b1;
    clear_logs();
  endtask

  // Presents a request and waits (bounded) for ready; k is the accepting cycle.
  task automatic send(input logic req, input logic [15:0] w, input logic [3:0] m,
                      output int k, output bit ok);
    ok = 1'b0;
    k  = -1;
    if (req) begin b_valid = 1'b1; b_word = w; b_mask = m; end
    else     begin a_valid = 1'b1; a_word = w; a_mask = m; end
    for (int t = 0; t < 20; t++) begin
      #1;
      if ((req ? b_ready : a_ready) === 1'b1) begin
        k  = cyc;
        ok = 1'b1;
        break;
      end
      @(posedge clock);
      #1;
    end
    if (ok) tick();
    if (req) b_valid = 1'b0;
    else     a_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({rw, data, port_id, busy, done, done_id, a_ready, b_ready} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got rw=%b data=%h pid=%0d busy=%b done=%b id=%b ar=%b br=%b, need all 0",
               rw, data, port_id, busy, done, done_id, a_ready, b_ready);
    end
  endtask

  task automatic test_full_mask();
    int k, k0;
    bit ok;
    logic [3:0] exp_d[4] = '{4'hF, 4'hE, 4'hE, 4'hB};
    do_reset();
    k0 = cyc;
    send(1'b0, 16'hBEEF, 4'b1111, k, ok);
    n_cmp++;
    if (!ok || k != k0) begin
      n_fail++;
      $display("FAIL full_accept: got ok=%0d k=%0d, need ok=1 k=%0d", ok, k, k0);
    end
    ticks(8);
    n_cmp++;
    if (wq.size() != 4) begin
      n_fail++;
      $display("FAIL full_count: got %0d writes, need 4", wq.size());
    end
    for (int i = 0; i < 4 && i < wq.size(); i++) begin
      n_cmp++;
      if (wq[i].c != k + 1 + i || wq[i].p !== 2'(i) || wq[i].d !== exp_d[i]) begin
        n_fail++;
        $display("FAIL full_write%0d: got c=%0d pid=%0d d=%h, need c=%0d pid=%0d d=%h",
                 i, wq[i].c, wq[i].p, wq[i].d, k + 1 + i, i, exp_d[i]);
      end
    end
    n_cmp++;
    if (dq.size() != 1 || dq[0].c != k + 5 || dq[0].id !== 1'b0) begin
      n_fail++;
      $display("FAIL full_done: got n=%0d c=%0d id=%b, need n=1 c=%0d id=0",
               dq.size(), dq.size() > 0 ? dq[0].c : -1, dq.size() > 0 ? dq[0].id : 1'bx, k + 5);
    end
  endtask

  task automatic test_sparse_mask();
    int k;
    bit ok;
    do_reset();
    send(1'b0, 16'h1234, 4'b1010, k, ok);
    ticks(6);
    n_cmp++;
    if (!ok || wq.size() != 2) begin
      n_fail++;
      $display("FAIL sparse_count: got ok=%0d writes=%0d, need ok=1 writes=2", ok, wq.size());
    end else begin
      n_cmp++;
      if (wq[0].c != k + 1 || wq[0].p !== 2'd1 || wq[0].d !== 4'h3) begin
        n_fail++;
        $display("FAIL sparse_w0: got c=%0d pid=%0d d=%h, need c=%0d pid=1 d=3",
                 wq[0].c, wq[0].p, wq[0].d, k + 1);
      end
      n_cmp++;
      if (wq[1].c != k + 2 || wq[1].p !== 2'd3 || wq[1].d !== 4'h1) begin
        n_fail++;
        $display("FAIL sparse_w1: got c=%0d pid=%0d d=%h, need c=%0d pid=3 d=1",
                 wq[1].c, wq[1].p, wq[1].d, k + 2);
      end
    end
    n_cmp++;
    if (dq.size() != 1 || dq[0].c != k + 3) begin
      n_fail++;
      $display("FAIL sparse_done: got n=%0d c=%0d, need n=1 c=%0d",
               dq.size(), dq.size() > 0 ? dq[0].c : -1, k + 3);
    end
  endtask

  task automatic test_round_robin();
    int k0;
    do_reset();
    a_word = 16'h1111; a_mask = 4'b0001; a_valid = 1'b1;
    b_word = 16'h2222; b_mask = 4'b0001; b_valid = 1'b1;
    #1;
    k0 = cyc;
    n_cmp++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_first_tie: got ar=%b br=%b, need ar=1 br=0", a_ready, b_ready);
    end
    ticks(12);
    a_valid = 1'b0;
    b_valid = 1'b0;
    ticks(4);
    n_cmp++;
    if (hq.size() != 4 || dq.size() != 4 || wq.size() != 4) begin
      n_fail++;
      $display("FAIL rr_counts: got hs=%0d done=%0d wr=%0d, need 4/4/4",
               hq.size(), dq.size(), wq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (hq[i].c != k0 + 3 * i || hq[i].id !== 1'(i % 2) ||
            dq[i].c != k0 + 3 * i + 2 || dq[i].id !== 1'(i % 2) ||
            wq[i].d !== ((i % 2) ? 4'h2 : 4'h1) || wq[i].p !== 2'd0) begin
          n_fail++;
          $display("FAIL rr_grant%0d: got hs c=%0d id=%b done c=%0d id=%b d=%h, need hs c=%0d id=%0d done c=%0d",
                   i, hq[i].c, hq[i].id, dq[i].c, dq[i].id, wq[i].d, k0 + 3 * i, i % 2, k0 + 3 * i + 2);
        end
      end
    end
  endtask

  task automatic test_zero_mask();
    int k;
    bit ok;
    do_reset();
    send(1'b1, 16'hABCD, 4'b0000, k, ok);
    ticks(4);
    n_cmp++;
    if (!ok || dq.size() != 1 || dq[0].c != k + 1 || dq[0].id !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_done: got ok=%0d n=%0d c=%0d, need ok=1 n=1 c=%0d id=1",
               ok, dq.size(), dq.size() > 0 ? dq[0].c : -1, k + 1);
    end
    n_cmp++;
    if (wq.size() != 0) begin
      n_fail++;
      $display("FAIL zero_no_write: got %0d writes, need 0", wq.size());
    end
  endtask

  task automatic test_reset_mid();
    int k;
    bit ok;
    do_reset();
    send(1'b0, 16'hBEEF, 4'b1111, k, ok);
    tick();
    reset = 1'b0;
    tick();
    n_cmp++;
    if (rw !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || data !== 4'h0 || port_id !== 2'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got rw=%b busy=%b done=%b data=%h pid=%0d, need 0",
               rw, busy, done, data, port_id);
    end
    reset = 1'b1;
    ticks(5);
    n_cmp++;
    if (!ok || dq.size() != 0 || wq.size() != 2) begin
      n_fail++;
      $display("FAIL midreset_abandon: got ok=%0d dones=%0d writes=%0d, need ok=1 0 dones 2 writes",
               ok, dq.size(), wq.size());
    end
    // last_grant must be back at B, so A wins a tie again
    a_valid = 1'b1; a_mask = 4'b0001;
    b_valid = 1'b1; b_mask = 4'b0001; b_word = 16'h0007;
    #1;
    n_cmp++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_lastgrant: got ar=%b br=%b, need ar=1 br=0", a_ready, b_ready);
    end
    a_valid = 1'b0;
    #1;
    n_cmp++;
    if (b_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_b_ready: got %b, need 1", b_ready);
    end
    tick();
    b_valid = 1'b0;
    ticks(3);
  endtask

  task automatic test_wait_during_write();
    int k, hi;
    bit ok;
    do_reset();
    send(1'b0, 16'hBEEF, 4'b1111, k, ok);
    b_word = 16'h00C5; b_mask = 4'b0011; b_valid = 1'b1;
    hi = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (b_ready === 1'b1) hi++;
      tick();
    end
    #1;
    n_cmp++;
    if (!ok || hi != 0 || b_ready !== 1'b1 || cyc != k + 6) begin
      n_fail++;
      $display("FAIL wait_ready: got ok=%0d early_ready=%0d br=%b cyc=%0d, need 1/0/1/%0d",
               ok, hi, b_ready, cyc, k + 6);
    end
    tick();
    b_valid = 1'b0;
    ticks(5);
    n_cmp++;
    if (wq.size() != 6 || dq.size() != 2) begin
      n_fail++;
      $display("FAIL wait_counts: got writes=%0d dones=%0d, need 6 and 2", wq.size(), dq.size());
    end else begin
      n_cmp++;
      if (wq[4].c != k + 7 || wq[4].p !== 2'd0 || wq[4].d !== 4'h5 ||
          wq[5].c != k + 8 || wq[5].p !== 2'd1 || wq[5].d !== 4'hC) begin
        n_fail++;
        $display("FAIL wait_b_writes: got (%0d,%0d,%h) (%0d,%0d,%h), need (%0d,0,5) (%0d,1,c)",
                 wq[4].c, wq[4].p, wq[4].d, wq[5].c, wq[5].p, wq[5].d, k + 7, k + 8);
      end
      n_cmp++;
      if (dq[1].c != k + 9 || dq[1].id !== 1'b1) begin
        n_fail++;
        $display("FAIL wait_b_done: got c=%0d id=%b, need c=%0d id=1", dq[1].c, dq[1].id, k + 9);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_mask();
    test_sparse_mask();
    test_round_robin();
    test_zero_mask();
    test_reset_mid();
    test_wait_during_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/output_write_sequencer.md
Name: output_write_sequencer

Overview:
- Shares the 4-bit indicator write bus (rw, data, port_id) between two requesters, A and B, using round-robin arbitration.
- Each requester submits a 16-bit indicator word and a 4-bit nibble mask.
- The sequencer breaks the word into one-cycle nibble writes, one per selected port, in ascending port order.
- Sits between the control unit / debug source and the indicator output register.

Parameters:
- PORTS, 4, number of 4-bit indicator ports; port_id width is clog2(PORTS).
- NIB_W, 4, nibble width; word width = PORTS*NIB_W.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low (reset==0 at rising edge clears all state).
- a_valid  in  1  requester A has a word pending.
- a_word  in  16  requester A indicator word; nibble i = bits [4i+3:4i].
- a_mask  in  4  requester A ports to write; bit i selects port i.
- a_ready  out  1  A's request is accepted this cycle (valid&ready at edge = handshake).
- b_valid, b_word, b_mask, b_ready  same as A, for requester B.
- rw  out  1  write strobe to indicator register.
- data  out  4  nibble being written.
- port_id  out  2  target port.
- busy  out  1  high in WRITE and DONE states.
- done  out  1  one-cycle pulse when a request completes.
- done_id  out  1  requester of the completing request (0=A, 1=B); valid with done.

Behaviour:
- Reset values: rw=0, data=0, port_id=0, done=0, done_id=0, busy=0, a_ready=b_ready=0. State=IDLE, last_grant=B, so A wins the first tie.
- States: IDLE, WRITE, DONE.
- IDLE:
  - a_ready/b_ready are combinational from valid and last_grant. Only one is ever high.
  - Only A valid -> a_ready=1. Only B valid -> b_ready=1.
  - Both valid -> the requester not equal to last_grant gets ready.
- Handshake in IDLE at edge k:
  - Latch the word, mask and requester id.
  - Set last_grant to the accepted requester.
  - Go to WRITE, or to DONE directly if mask==0.
- WRITE:
  - Each cycle, drive rw=1, port_id=lowest set bit of the remaining mask, data=the corresponding latched nibble.
  - Clear that bit. When the remaining mask becomes 0, go to DONE.
  - Outputs are registered: for a mask with n set bits, rw is high in cycles k+1..k+n, with strictly ascending port_id and no gaps.
- DONE:
  - done=1, done_id=latched id, rw=0; lasts one cycle, then IDLE.
  - Completion cycle is k+n+1, or k+1 for mask==0.
  - Earliest next handshake is at the edge ending cycle k+n+2.
- Outside WRITE cycles: rw=0, data=0, port_id=0.
- a_ready/b_ready are 0 in WRITE and DONE. Requests arriving then wait; they are not lost while valid is held.
- Requester rules:
  - Must hold valid, word and mask stable until ready.
  - Dropping valid before ready withdraws the request without side effects.
- Round-robin guarantee: with both requesters continuously valid, grants alternate A, B, A, B.
- Reset mid-operation (reset==0 in any state):
  - Abandon the transfer; outputs go to reset values on that edge.
  - No done pulse for the abandoned request; last_grant returns to B.
  - Nibbles already written stay in the indicator register unless it is reset too.
- Full mask 4'b1111: exactly 4 write cycles, port_id 0,1,2,3.

Decomposition:
- Shared package output_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_WRITE=2'd1, ST_DONE=2'd2.
  - PORTS, NIB_W, PORT_ID_W=2, requester ids REQ_A=1'b0, REQ_B=1'b1.
- One sub-module, rr_arbiter2:
  - Inputs: valid[1:0], last_grant, enable (state==IDLE).
  - Outputs: one-hot ready[1:0] and grant id. Purely combinational.
- Lowest-set-bit selection and the state machine stay in the top module.

Test Plan:
- Reset, then A: word=16'hBEEF, mask=4'b1111.
  - a_ready at cycle 0.
  - rw=1 cycles 1-4 with (port_id,data) = (0,F), (1,E), (2,E), (3,B).
  - done=1, done_id=0 at cycle 5.
- A: word=16'h1234, mask=4'b1010.
  - Exactly 2 writes: (1,3) then (3,1).
  - done at accept+3; port_id 0 and 2 never strobed.
- A and B both valid from reset: A word 16'h1111 mask 4'b0001, B word 16'h2222 mask 4'b0001.
  - A granted first, B granted in IDLE after A's DONE; done_id sequence 0, 1.
  - With both held continuously for 4 requests, grants go A, B, A, B.
- B: mask=4'b0000.
  - b_ready, then done=1, done_id=1 the next cycle; rw never asserted.
- Reset mid-WRITE: A with mask 4'b1111, drive reset=0 in cycle 2.
  - At that edge, rw/busy/done go 0 and no done pulse follows.
  - After reset=1, a B-only request is granted in the first IDLE cycle.
- B valid asserted during A's WRITE.
  - b_ready stays 0 until A's DONE completes, then b_ready=1 in IDLE.
  - B's writes begin the cycle after its handshake.
